// File: rtl/reg_bank_pkg.sv
// Shared constants and types for the 16 x 32 general-purpose register file.
package reg_bank_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 4;
    localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

    typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [DATA_WIDTH-1:0] reg_data_t;

endpackage : reg_bank_pkg

// File: rtl/bank_reg32.sv
// Single enable-gated storage register of the register bank.
// Synchronous reset has priority over the load enable.
module bank_reg32
    import reg_bank_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    // Storage: clear on reset, load d when enabled, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= {WIDTH{1'b0}};
        end else if (en) begin
            r_q <= d;
        end else begin
            r_q <= r_q;
        end
    end

    assign q = r_q;

endmodule : bank_reg32

// File: rtl/reg_bank_16x32.sv
// General-purpose register file: one synchronous write port and two
// independent combinational read ports. Writes become visible only after
// the capturing clock edge; there is no write-to-read bypass.
module reg_bank_16x32 #(
    parameter int DATA_WIDTH = reg_bank_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = reg_bank_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] dest_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] src1_addr,
    input  logic [ADDR_WIDTH-1:0] src2_addr,
    output logic [DATA_WIDTH-1:0] src1_data,
    output logic [DATA_WIDTH-1:0] src2_data
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [NUM_REGS-1:0]   w_dec;
    logic [NUM_REGS-1:0]   w_wen;
    logic [DATA_WIDTH-1:0] w_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] w_rd1;
    logic [DATA_WIDTH-1:0] w_rd2;

    // Write-address decoder: exactly one bit set for every dest_addr value.
    always_comb begin
        w_dec = {NUM_REGS{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            if (dest_addr == ADDR_WIDTH'(i)) begin
                w_dec[i] = 1'b1;
            end else begin
                w_dec[i] = 1'b0;
            end
        end
    end

    // Per-register load enables; address/data activity with wr_en low
    // cannot reach any register.
    assign w_wen = w_dec & {NUM_REGS{wr_en}};

    // Storage array: sixteen independently enabled registers.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
        bank_reg32 #(
            .WIDTH (DATA_WIDTH)
        ) u_reg (
            .clk (clk),
            .rst (rst),
            .en  (w_wen[g]),
            .d   (wr_data),
            .q   (w_q[g])
        );
    end

    // Read port 1 multiplexer: purely combinational selection.
    always_comb begin
        w_rd1 = {DATA_WIDTH{1'b0}};
        w_rd1 = w_q[src1_addr];
    end

    // Read port 2 multiplexer: independent of port 1.
    always_comb begin
        w_rd2 = {DATA_WIDTH{1'b0}};
        w_rd2 = w_q[src2_addr];
    end

    assign src1_data = w_rd1;
    assign src2_data = w_rd2;

endmodule : reg_bank_16x32

// File: tb/tb_reg_bank_16x32.sv
// Directed self-checking bench for reg_bank_16x32 with a reference model
// and an expected-value queue.
module tb_reg_bank_16x32;
    import reg_bank_pkg::*;

    logic      clk;
    logic      rst;
    logic      wr_en;
    reg_addr_t dest_addr;
    reg_data_t wr_data;
    reg_addr_t src1_addr;
    reg_addr_t src2_addr;
    reg_data_t src1_data;
    reg_data_t src2_data;

    int checks   = 0;
    int failures = 0;

    reg_data_t mdl [NUM_REGS];
    reg_data_t sb [$];

    reg_bank_16x32 dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .dest_addr (dest_addr),
        .wr_data   (wr_data),
        .src1_addr (src1_addr),
        .src2_addr (src2_addr),
        .src1_data (src1_data),
        .src2_data (src2_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Queue expectations for both ports, let the read settle, then compare.
    task automatic rd(input reg_addr_t a1, input reg_addr_t a2, input string tag);
        reg_data_t e;
        src1_addr = a1;
        src2_addr = a2;
        sb.push_back(mdl[a1]);
        sb.push_back(mdl[a2]);
        #1;
        e = sb.pop_front();
        checks++;
        assert (src1_data === e) else begin
            failures++;
            $error("FAIL %s port1 addr=%0d observed=%h expected=%h", tag, a1, src1_data, e);
        end
        e = sb.pop_front();
        checks++;
        assert (src2_data === e) else begin
            failures++;
            $error("FAIL %s port2 addr=%0d observed=%h expected=%h", tag, a2, src2_data, e);
        end
    endtask

    // One write cycle; the model updates only after the capturing edge.
    task automatic wr(input reg_addr_t a, input reg_data_t d);
        wr_en     = 1'b1;
        dest_addr = a;
        wr_data   = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        mdl[a] = d;
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < NUM_REGS; i++) begin
            rd(reg_addr_t'(i), reg_addr_t'(NUM_REGS - 1 - i), tag);
        end
    endtask

    initial begin
        src1_addr = 4'd0;
        src2_addr = 4'd0;

        // Reset with a simultaneous write attempt: reset wins.
        rst       = 1'b1;
        wr_en     = 1'b1;
        dest_addr = 4'd5;
        wr_data   = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REGS; i++) mdl[i] = 32'h0000_0000;
        rd(4'd5, 4'd0, "reset_during");
        rst   = 1'b0;
        wr_en = 1'b0;
        sweep("reset");

        // Fill every register, then read crosswise.
        for (int i = 0; i < NUM_REGS; i++) begin
            wr(reg_addr_t'(i), 32'hA5A5_0000 + 32'(i));
        end
        sweep("write_all");

        // Disabled write, with address/data wiggling inside the cycle.
        wr_en     = 1'b0;
        dest_addr = 4'd3;
        wr_data   = 32'hDEAD_BEEF;
        #2;
        dest_addr = 4'd0;
        wr_data   = 32'h1111_1111;
        #2;
        dest_addr = 4'd3;
        wr_data   = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        sweep("wr_disabled");

        // No bypass: the old value is visible until the capturing edge.
        wr_en     = 1'b1;
        dest_addr = 4'd7;
        wr_data   = 32'h1234_5678;
        rd(4'd7, 4'd8, "no_bypass_before");
        @(posedge clk);
        #1;
        wr_en  = 1'b0;
        mdl[7] = 32'h1234_5678;
        rd(4'd7, 4'd6, "no_bypass_after");

        // Only the data present at the edge is captured.
        wr_en     = 1'b1;
        dest_addr = 4'd9;
        wr_data   = 32'hBAD0_0BAD;
        #2;
        wr_data   = 32'h0C0F_FEE0;
        @(posedge clk);
        #1;
        wr_en  = 1'b0;
        mdl[9] = 32'h0C0F_FEE0;
        rd(4'd9, 4'd10, "edge_sample");

        // Both ports on the same address, before and after a write.
        rd(4'd15, 4'd15, "dual_same");
        wr(4'd15, 32'h0000_0000);
        rd(4'd15, 4'd15, "dual_same_after");

        // Boundary address 0.
        wr(4'd0, 32'hFEDC_BA98);
        rd(4'd0, 4'd15, "boundary");

        // Reset mid-operation while a write to register 0 is requested.
        rst       = 1'b1;
        wr_en     = 1'b1;
        dest_addr = 4'd0;
        wr_data   = 32'h0000_0001;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        wr_en = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) mdl[i] = 32'h0000_0000;
        sweep("reset_mid");

        // Normal writes resume after reset.
        wr(4'd0, 32'h0000_0001);
        rd(4'd0, 4'd1, "post_reset_write");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_reg_bank_16x32

// File: doc/reg_bank_16x32.md
Name: reg_bank_16x32

Overview:
- General-purpose register file for the datapath: 16 registers of 32 bits, one synchronous write port and two asynchronous read ports.
- Built from three pieces:
  - a 4-to-16 one-hot write-address decoder;
  - sixteen enable-gated 32-bit registers;
  - two 16:1 read multiplexers.
- Write data comes from the load/ALU result mux. The read outputs feed the ALU operand paths.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports.
- ADDR_WIDTH, 4, register address width. Register count NUM_REGS = 2**ADDR_WIDTH = 16. Only the default is required to be verified.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  write enable for the destination register.
- dest_addr  input  ADDR_WIDTH  destination register index.
- wr_data  input  DATA_WIDTH  write data (load/result mux output).
- src1_addr  input  ADDR_WIDTH  read port 1 register index.
- src2_addr  input  ADDR_WIDTH  read port 2 register index.
- src1_data  output  DATA_WIDTH  contents of register src1_addr.
- src2_data  output  DATA_WIDTH  contents of register src2_addr.

Behaviour:
- Decoder: combinational one-hot of dest_addr.
  - dec[i] = 1 if and only if dest_addr == i.
  - Exactly one bit is set for every input value.
- Register write enable for register i = wr_en AND dec[i].
- On the rising edge of clk:
  - If rst = 1: all 16 registers become 0x00000000. Reset overrides any write in the same cycle.
  - Else if wr_en = 1: register[dest_addr] <= wr_data. All other registers hold.
  - Else: all registers hold.
- Reads are purely combinational. src1_data = register[src1_addr] and src2_data = register[src2_addr], with no clock latency.
- Both read ports are independent. Same address on both ports returns identical data.
- Write latency: new data is visible on a read port after the rising edge that captures it.
  - No write-to-read bypass.
  - Reading dest_addr in the same cycle as the write returns the old value until the edge.
- All 16 registers are ordinary storage. Register 0 is not hardwired to zero.
- Output values:
  - During and after reset, both read ports output 0x00000000 for every address.
  - Before the first reset, register contents are undefined.
- Reset asserted mid-operation clears all registers at the next edge, regardless of wr_en, dest_addr or wr_data. Reads reflect zeros immediately after that edge.
- Boundary addresses 0 and 15 behave identically to all others. There is no out-of-range case.
- Glitch-free write requirement: dest_addr and wr_data changing while wr_en = 0 never alters state.
- Sampling of wr_en, dest_addr and wr_data: values at the clock edge only; intermediate changes within the cycle have no effect.

Decomposition:
- Shared package reg_bank_pkg holds:
  - constants DATA_WIDTH = 32, ADDR_WIDTH = 4, NUM_REGS = 16;
  - typedefs reg_addr_t (ADDR_WIDTH bits) and reg_data_t (DATA_WIDTH bits).
- One sub-module is natural: bank_reg32, a single DATA_WIDTH register with clk, rst, en, d, q, instantiated 16 times via generate.
- Decoder and both read muxes are implemented inline as combinational logic in the top.

Test Plan:
- Reset: assert rst for one edge with wr_en = 1, dest_addr = 5, wr_data = 0xFFFFFFFF. Then sweep src1_addr/src2_addr over 0..15 → all reads 0x00000000.
- Write/read all registers:
  - For i = 0..15, write 0xA5A50000 + i with wr_en = 1.
  - Then read src1_addr = i and src2_addr = 15 - i → 0xA5A50000 + i and 0xA5A50000 + (15 - i).
- Write disabled: wr_en = 0, dest_addr = 3, wr_data = 0xDEADBEEF, one edge → register 3 still 0xA5A50003; no other register changed.
- No bypass:
  - Before the edge, with wr_en = 1, dest_addr = 7, wr_data = 0x12345678 and src1_addr = 7 → src1_data = old value 0xA5A50007.
  - After the edge → src1_data = 0x12345678.
- Dual read, same address: src1_addr = src2_addr = 15 → both outputs 0xA5A5000F, and both change together after writing 0x0 to register 15.
- Reset mid-operation:
  - Populate registers, then assert rst while wr_en = 1, dest_addr = 0, wr_data = 0x1 → register 0 and all others read 0x00000000.
  - After rst deasserts, a write of 0x1 to register 0 succeeds.
